// File: rtl/cond_decode_unit_pkg.sv
// Shared constants for instruction decode and condition evaluation: condition
// codes, compare-type opcodes, instruction classes and NZCV bit positions.
package cond_decode_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam logic [3:0] OPC_TST = 4'b1000;
    localparam logic [3:0] OPC_CMP = 4'b1010;

    localparam logic [2:0] INST_DP = 3'b000;
    localparam logic [2:0] INST_DT = 3'b010;
    localparam logic [2:0] INST_BR = 3'b101;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Fields the controller and datapath consume, sliced from the IR.
    typedef struct packed {
        logic [2:0]  inst;
        logic        i;
        logic        e;
        logic        l_tr;
        logic        l_br;
        logic [3:0]  opcode;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [11:0] imm12;
        logic [23:0] imm24;
    } decode_t;

endpackage

// File: rtl/cond_decode_unit_cond_eval.sv
// Combinational condition check: maps a 4-bit condition code and the NZCV
// flags to a single pass bit.
module cond_eval
    import cond_decode_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_decode_unit.sv
// Instruction and flag registers with field decode and a registered
// condition-pass bit D for the multicycle controller's CheckC state.
module cond_decode_unit
    import cond_decode_unit_pkg::*;
#(
    parameter int         IW       = 32,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          IRWrite,
    input  logic [IW-1:0] mem_rdata,
    input  logic          flag_write,
    input  logic [3:0]    alu_nzcv,
    output logic [IW-1:0] IR,
    output logic [3:0]    flags,
    output logic          D,
    output logic [2:0]    Inst,
    output logic          I,
    output logic          E,
    output logic          L_tr,
    output logic          L_br,
    output logic [3:0]    opcode,
    output logic [3:0]    Rn,
    output logic [3:0]    Rd,
    output logic [3:0]    Rm,
    output logic [11:0]   imm12,
    output logic [23:0]   imm24
);

    // No handshake: IRWrite and flag_write are plain per-cycle load enables.
    logic    cond_pass;
    decode_t dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            IR <= '0;
        end else if (IRWrite) begin
            IR <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= FLAG_RST;
        end else if (flag_write) begin
            flags <= alu_nzcv;
        end
    end

    // D samples the pre-edge IR and flags, so it trails any load by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            D <= 1'b0;
        end else begin
            D <= cond_pass;
        end
    end

    cond_eval u_cond_eval (
        .cond (IR[31:28]),
        .nzcv (flags),
        .pass (cond_pass)
    );

    always_comb begin
        dec        = '0;
        dec.inst   = IR[27:25];
        dec.i      = IR[24];
        dec.opcode = IR[23:20];
        dec.e      = (IR[23:20] == OPC_TST) || (IR[23:20] == OPC_CMP);
        dec.l_tr   = IR[20];
        dec.l_br   = IR[24];
        dec.rn     = IR[19:16];
        dec.rd     = IR[15:12];
        dec.rm     = IR[3:0];
        dec.imm12  = IR[11:0];
        dec.imm24  = IR[23:0];
    end

    assign Inst   = dec.inst;
    assign I      = dec.i;
    assign E      = dec.e;
    assign L_tr   = dec.l_tr;
    assign L_br   = dec.l_br;
    assign opcode = dec.opcode;
    assign Rn     = dec.rn;
    assign Rd     = dec.rd;
    assign Rm     = dec.rm;
    assign imm12  = dec.imm12;
    assign imm24  = dec.imm24;

endmodule

// File: tb/tb_cond_decode_unit.sv
// Self-checking bench for cond_decode_unit: a cycle-level reference model
// feeding an expected queue, plus directed literal checks.
module tb_cond_decode_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        IRWrite = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        flag_write = 1'b0;
    logic [3:0]  alu_nzcv = '0;
    logic [31:0] IR;
    logic [3:0]  flags;
    logic        D;
    logic [2:0]  Inst;
    logic        I, E, L_tr, L_br;
    logic [3:0]  opcode, Rn, Rd, Rm;
    logic [11:0] imm12;
    logic [23:0] imm24;

    int n_checks = 0;
    int n_fail   = 0;

    cond_decode_unit #(.IW(32), .FLAG_RST(4'b0000)) dut (
        .clk(clk), .rst(rst), .IRWrite(IRWrite), .mem_rdata(mem_rdata),
        .flag_write(flag_write), .alu_nzcv(alu_nzcv), .IR(IR), .flags(flags),
        .D(D), .Inst(Inst), .I(I), .E(E), .L_tr(L_tr), .L_br(L_br),
        .opcode(opcode), .Rn(Rn), .Rd(Rd), .Rm(Rm), .imm12(imm12), .imm24(imm24)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Even codes test a base predicate; each odd code is its complement.
    function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? ~base : base;
    endfunction

    logic [31:0] m_ir = '0;
    logic [3:0]  m_flags = '0;
    logic        m_d = 1'b0;
    bit          m_valid = 0;
    logic [36:0] exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_ir = '0; m_flags = '0; m_d = 1'b0; m_valid = 1;
        end else begin
            m_d = model_pass(m_ir[31:28], m_flags);
            if (IRWrite)    m_ir = mem_rdata;
            if (flag_write) m_flags = alu_nzcv;
        end
        if (m_valid) exp_q.push_back({m_d, m_ir, m_flags});
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [36:0] e;
        logic [31:0] eir;
        logic [62:0] exp_dec, act_dec;
        logic        exp_e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            eir = e[35:4];
            n_checks++;
            if (D !== e[36]) begin
                n_fail++;
                $display("FAIL sb_D t=%0t got=%b want=%b", $time, D, e[36]);
            end
            n_checks++;
            if (IR !== eir || flags !== e[3:0]) begin
                n_fail++;
                $display("FAIL sb_regs t=%0t got IR=%h flags=%b want IR=%h flags=%b",
                         $time, IR, flags, eir, e[3:0]);
            end
            exp_e   = (eir[23:20] == 4'd8) || (eir[23:20] == 4'd10);
            exp_dec = {eir[27:25], eir[24], exp_e, eir[20], eir[24], eir[23:20],
                       eir[19:16], eir[15:12], eir[3:0], eir[11:0], eir[23:0]};
            act_dec = {Inst, I, E, L_tr, L_br, opcode, Rn, Rd, Rm, imm12, imm24};
            n_checks++;
            if (act_dec !== exp_dec) begin
                n_fail++;
                $display("FAIL sb_decode t=%0t got=%h want=%h", $time, act_dec, exp_dec);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic irw, input logic [31:0] rd,
                         input logic fw, input logic [3:0] nz);
        rst = r; IRWrite = irw; mem_rdata = rd; flag_write = fw; alu_nzcv = nz;
        @(posedge clk);
        #1;
        rst = 1'b0; IRWrite = 1'b0; flag_write = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset wins over both load enables
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 4'hF);
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 4'hF);
        chk("rst_IR", IR, 32'h0);
        chk("rst_flags", {28'h0, flags}, 32'h0);
        chk("rst_D", {31'h0, D}, 32'h0);

        // EQ branch-and-link, loaded together with Z=1
        drive(1'b0, 1'b1, 32'h0B00_0010, 1'b1, 4'b0100);
        chk("bl_Inst", {29'h0, Inst}, 32'h5);
        chk("bl_L_br", {31'h0, L_br}, 32'h1);
        chk("bl_imm24", {8'h0, imm24}, 32'h0000_0010);
        chk("bl_D_load", {31'h0, D}, 32'h0);
        idle();
        chk("bl_D_next", {31'h0, D}, 32'h1);

        // CMP and ADD decode
        drive(1'b0, 1'b1, 32'hE1A1_2003, 1'b0, 4'h0);
        chk("cmp_E", {31'h0, E}, 32'h1);
        chk("cmp_fields", {16'h0, Rn, Rd, Rm, 3'b0, I}, 32'h0000_1231);
        drive(1'b0, 1'b1, 32'hE041_2003, 1'b0, 4'h0);
        chk("add_E", {31'h0, E}, 32'h0);

        // GT spot checks
        drive(1'b0, 1'b1, 32'hC000_0000, 1'b1, 4'b1001);
        idle();
        chk("gt_1001", {31'h0, D}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 4'b1000);
        idle();
        chk("gt_1000", {31'h0, D}, 32'h0);

        // Full sweep of condition x flags, checked by the scoreboard
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, 1'b1, {c[3:0], 28'h0123_456}, 1'b0, 4'h0);
            for (int f = 0; f < 16; f++) begin
                drive(1'b0, 1'b0, 32'h0, 1'b1, f[3:0]);
                idle();
            end
        end

        // Same-cycle IR and flag load: old/old first, then new/new
        drive(1'b0, 1'b1, 32'h0000_0000, 1'b1, 4'b0100);
        idle();
        chk("same_pre", {31'h0, D}, 32'h1);
        drive(1'b0, 1'b1, 32'h1000_0000, 1'b1, 4'b0000);
        chk("same_old", {31'h0, D}, 32'h1);
        idle();
        chk("same_new", {31'h0, D}, 32'h1);

        // NV never passes
        drive(1'b0, 1'b1, 32'hF000_0000, 1'b1, 4'hF);
        idle();
        chk("nv_F", {31'h0, D}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 4'h0);
        idle();
        chk("nv_0", {31'h0, D}, 32'h0);

        // Reset mid-instruction, then AL after reset
        drive(1'b0, 1'b1, 32'hE000_0000, 1'b0, 4'h0);
        idle();
        chk("al_pre", {31'h0, D}, 32'h1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 4'h0);
        chk("mid_rst_D", {31'h0, D}, 32'h0);
        chk("mid_rst_IR", IR, 32'h0);
        drive(1'b0, 1'b1, 32'hE000_0000, 1'b0, 4'h0);
        chk("al_load", {31'h0, D}, 32'h0);
        idle();
        chk("al_after", {31'h0, D}, 32'h1);

        idle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
